// File: rtl/register_file_pkg.sv
// rtl/register_file_pkg.sv - shared constants and read-port address slicing helper
package register_file_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int MAX_ADDR_WIDTH = 8;
  localparam int MAX_RD_PORTS   = 4;
  localparam int RD_VEC_W       = MAX_ADDR_WIDTH * MAX_RD_PORTS;

  // Extract port 'port' from a packed address vector (zero-extended to RD_VEC_W).
  function automatic logic [MAX_ADDR_WIDTH-1:0] rd_addr_slice(
    input logic [RD_VEC_W-1:0] vec,
    input int                  port,
    input int                  addr_width
  );
    logic [RD_VEC_W-1:0]       shifted;
    logic [MAX_ADDR_WIDTH-1:0] mask;
    shifted = vec >> (port * addr_width);
    mask    = '0;
    for (int i = 0; i < MAX_ADDR_WIDTH; i++) begin
      if (i < addr_width) mask[i] = 1'b1;
    end
    return shifted[MAX_ADDR_WIDTH-1:0] & mask;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - pending-register scoreboard with reservation check and count
module regfile_scoreboard
  import register_file_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ZERO_REG   = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_wr_en,
  input  logic [ADDR_WIDTH-1:0]     i_wr_dest,
  input  logic                      i_rsv_en,
  input  logic [ADDR_WIDTH-1:0]     i_rsv_addr,
  input  logic                      i_flush,
  output logic [(2**ADDR_WIDTH)-1:0] o_busy,
  output logic                      o_rsv_ok,
  output logic                      o_rsv_err,
  output logic [ADDR_WIDTH:0]       o_busy_count
);

  localparam int REG_NUM = 2 ** ADDR_WIDTH;

  logic [REG_NUM-1:0] r_busy;
  logic [ADDR_WIDTH:0] r_count;
  logic               r_err;
  logic [REG_NUM-1:0] w_wr_mask;
  logic [REG_NUM-1:0] w_busy_kept;
  logic [REG_NUM-1:0] w_busy_next;
  logic [ADDR_WIDTH:0] w_count_next;
  logic               w_rsv_zero;
  logic               w_wr_hit;
  logic               w_take;
  logic               w_inc;
  logic               w_dec;

  assign w_rsv_zero = (ZERO_REG != 0) && (i_rsv_addr == '0);
  assign w_wr_hit   = i_wr_en && (i_wr_dest == i_rsv_addr);
  // A busy target is still acceptable when its pending write lands this cycle.
  assign o_rsv_ok   = w_rsv_zero || !r_busy[i_rsv_addr] || w_wr_hit;
  assign w_take     = i_rsv_en && o_rsv_ok && !w_rsv_zero;

  assign w_wr_mask   = i_wr_en ? (REG_NUM'(1) << i_wr_dest) : '0;
  assign w_busy_kept = r_busy & ~w_wr_mask;
  assign w_dec       = i_wr_en && r_busy[i_wr_dest];
  assign w_inc       = w_take && !w_busy_kept[i_rsv_addr];

  // Next-state busy bits and count; the reservation is applied after the write-clear so it wins.
  always_comb begin
    w_busy_next  = w_busy_kept;
    w_count_next = r_count + (ADDR_WIDTH+1)'(w_inc) - (ADDR_WIDTH+1)'(w_dec);
    if (w_take) w_busy_next[i_rsv_addr] = 1'b1;
    if (i_flush) begin
      w_busy_next  = '0;
      w_count_next = '0;
    end
  end

  // Scoreboard state; flush overrides reservations, so it cannot raise the error flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_busy  <= w_busy_next;
      r_count <= w_count_next;
      if (i_rsv_en && !o_rsv_ok && !i_flush) r_err <= 1'b1;
    end
  end

  assign o_busy       = r_busy;
  assign o_busy_count = r_count;
  assign o_rsv_err    = r_err;

endmodule

// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - multi-read-port register file with bypass and scoreboard
module register_file_mp
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int NUM_RD_PORTS = 2,
  parameter int ZERO_REG     = 1,
  parameter int BYPASS_EN    = 1
) (
  input  logic                               clk_in,
  input  logic                               rst_n_in,
  input  logic                               reg_wr_en,
  input  logic [ADDR_WIDTH-1:0]              reg_wr_dest,
  input  logic [DATA_WIDTH-1:0]              reg_wr_data,
  input  logic                               rsv_en,
  input  logic [ADDR_WIDTH-1:0]              rsv_addr,
  input  logic                               sb_flush,
  input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] reg_rd_addr,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] reg_rd_data,
  output logic [NUM_RD_PORTS-1:0]            reg_rd_busy,
  output logic                               rsv_ok,
  output logic [ADDR_WIDTH:0]                busy_count,
  output logic                               rsv_err
);

  localparam int REG_NUM = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_reg_array [REG_NUM];
  logic [REG_NUM-1:0]    w_busy;
  logic [RD_VEC_W-1:0]   w_rd_addr_ext;
  logic                  w_wr_commit;

  assign w_rd_addr_ext = RD_VEC_W'(reg_rd_addr);
  assign w_wr_commit   = reg_wr_en && !((ZERO_REG != 0) && (reg_wr_dest == '0));

  // Data array: one-cycle write, cleared asynchronously on reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < REG_NUM; i++) r_reg_array[i] <= '0;
    end else if (w_wr_commit) begin
      r_reg_array[reg_wr_dest] <= reg_wr_data;
    end
  end

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .i_clk        (clk_in),
    .i_rst_n      (rst_n_in),
    .i_wr_en      (reg_wr_en),
    .i_wr_dest    (reg_wr_dest),
    .i_rsv_en     (rsv_en),
    .i_rsv_addr   (rsv_addr),
    .i_flush      (sb_flush),
    .o_busy       (w_busy),
    .o_rsv_ok     (rsv_ok),
    .o_rsv_err    (rsv_err),
    .o_busy_count (busy_count)
  );

  for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_is_zero;
    logic                  w_fwd;
    logic [DATA_WIDTH-1:0] w_data;

    assign w_addr    = ADDR_WIDTH'(rd_addr_slice(w_rd_addr_ext, k, ADDR_WIDTH));
    assign w_is_zero = (ZERO_REG != 0) && (w_addr == '0);
    assign w_fwd     = (BYPASS_EN != 0) && reg_wr_en && (reg_wr_dest == w_addr) && !w_is_zero;

    // Read mux: outputs are forced low while reset is held so bypassed data cannot leak.
    always_comb begin
      w_data = r_reg_array[w_addr];
      if (w_fwd) w_data = reg_wr_data;
      if (!rst_n_in || w_is_zero) w_data = '0;
    end

    assign reg_rd_data[k*DATA_WIDTH +: DATA_WIDTH] = w_data;
    assign reg_rd_busy[k] = rst_n_in && w_busy[w_addr] && !w_fwd;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// tb/tb_register_file_mp.sv - table, directed and randomized checks of register_file_mp
module tb_register_file_mp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reg_wr_en;
  logic [2:0]  reg_wr_dest;
  logic [15:0] reg_wr_data;
  logic        rsv_en;
  logic [2:0]  rsv_addr;
  logic        sb_flush;
  logic [5:0]  reg_rd_addr;
  logic [31:0] reg_rd_data;
  logic [1:0]  reg_rd_busy;
  logic        rsv_ok;
  logic [3:0]  busy_count;
  logic        rsv_err;
  logic [2:0]  a0, a1;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_reg [8];
  bit          m_busy [8];
  bit          m_err;

  typedef struct {
    logic        we; logic [2:0] wd; logic [15:0] wdat;
    logic        re; logic [2:0] ra; logic fl;
    logic [2:0]  a0; logic [2:0] a1;
    logic [15:0] d0; logic [15:0] d1;
    logic        b0; logic b1; logic ok; logic [3:0] cnt; logic err;
  } vec_t;
  vec_t tbl [$];

  register_file_mp dut (
    .clk_in      (clk),
    .rst_n_in    (rst_n),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_dest (reg_wr_dest),
    .reg_wr_data (reg_wr_data),
    .rsv_en      (rsv_en),
    .rsv_addr    (rsv_addr),
    .sb_flush    (sb_flush),
    .reg_rd_addr (reg_rd_addr),
    .reg_rd_data (reg_rd_data),
    .reg_rd_busy (reg_rd_busy),
    .rsv_ok      (rsv_ok),
    .busy_count  (busy_count),
    .rsv_err     (rsv_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] wd, input logic [15:0] wdat,
                       input logic re, input logic [2:0] ra, input logic fl,
                       input logic [2:0] p0, input logic [2:0] p1);
    reg_wr_en = we; reg_wr_dest = wd; reg_wr_data = wdat;
    rsv_en = re; rsv_addr = ra; sb_flush = fl;
    a0 = p0; a1 = p1; reg_rd_addr = {p1, p0};
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin m_reg[i] = '0; m_busy[i] = 0; end
    m_err = 0;
  endtask

  function automatic logic [15:0] exp_rd(input logic [2:0] a);
    if (a == 0) return 16'h0;
    if (reg_wr_en && reg_wr_dest == a) return reg_wr_data;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input logic [2:0] a);
    return m_busy[a] && !(reg_wr_en && reg_wr_dest == a);
  endfunction

  function automatic logic exp_ok();
    return (rsv_addr == 0) || !m_busy[rsv_addr] || (reg_wr_en && reg_wr_dest == rsv_addr);
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, "_data"}, 64'(reg_rd_data), 64'({exp_rd(a1), exp_rd(a0)}));
    chk({tag, "_busy"}, 64'(reg_rd_busy), 64'({exp_busy(a1), exp_busy(a0)}));
    chk({tag, "_ok"},   64'(rsv_ok),      64'(exp_ok()));
    chk({tag, "_cnt"},  64'(busy_count),  64'(exp_cnt()));
    chk({tag, "_err"},  64'(rsv_err),     64'(m_err));
  endtask

  // Advance one clock edge and apply the architectural effect of the held inputs.
  task automatic step();
    bit ok;
    ok = exp_ok();
    @(posedge clk);
    if (reg_wr_en && reg_wr_dest != 0) m_reg[reg_wr_dest] = reg_wr_data;
    if (sb_flush) begin
      for (int i = 0; i < 8; i++) m_busy[i] = 0;
    end else begin
      if (reg_wr_en) m_busy[reg_wr_dest] = 0;
      if (rsv_en && ok && rsv_addr != 0) m_busy[rsv_addr] = 1;
      if (rsv_en && !ok) m_err = 1;
    end
    @(negedge clk);
  endtask

  initial begin
    tbl.push_back('{1,3,16'hBEEF,0,0,0, 3,5, 16'hBEEF,16'h0,    0,0,1,0,0});
    tbl.push_back('{0,0,16'h0,   0,0,0, 3,3, 16'hBEEF,16'hBEEF, 0,0,1,0,0});
    tbl.push_back('{0,0,16'h0,   1,5,0, 5,3, 16'h0,   16'hBEEF, 0,0,1,0,0});
    tbl.push_back('{0,0,16'h0,   1,5,0, 5,3, 16'h0,   16'hBEEF, 1,0,0,1,0});
    tbl.push_back('{0,0,16'h0,   0,0,0, 5,0, 16'h0,   16'h0,    1,0,1,1,1});
    tbl.push_back('{0,0,16'h0,   1,2,0, 2,5, 16'h0,   16'h0,    0,1,1,1,1});
    tbl.push_back('{1,2,16'h00A2,1,2,0, 2,5, 16'h00A2,16'h0,    0,1,1,2,1});
    tbl.push_back('{0,0,16'h0,   0,0,0, 2,5, 16'h00A2,16'h0,    1,1,1,2,1});
    tbl.push_back('{1,5,16'h0555,0,0,0, 5,2, 16'h0555,16'h00A2, 0,1,1,2,1});
    tbl.push_back('{0,0,16'h0,   0,0,0, 5,2, 16'h0555,16'h00A2, 0,1,1,1,1});
    tbl.push_back('{0,0,16'h0,   1,1,0, 1,2, 16'h0,   16'h00A2, 0,1,1,1,1});
    tbl.push_back('{0,0,16'h0,   1,4,0, 4,1, 16'h0,   16'h0,    0,1,1,2,1});
    tbl.push_back('{0,0,16'h0,   1,6,1, 6,4, 16'h0,   16'h0,    0,1,1,3,1});
    tbl.push_back('{0,0,16'h0,   0,0,0, 6,4, 16'h0,   16'h0,    0,0,1,0,1});
    tbl.push_back('{1,0,16'h1234,1,0,0, 0,0, 16'h0,   16'h0,    0,0,1,0,1});
    tbl.push_back('{0,0,16'h0,   0,0,0, 0,0, 16'h0,   16'h0,    0,0,1,0,1});

    model_reset();
    drive(0, 0, 16'h0, 0, 0, 0, 0, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Post-reset sweep of every register on both ports.
    for (int a = 0; a < 8; a++) begin
      drive(0, 0, 16'h0, 0, 0, 0, 3'(a), 3'(7 - a));
      #1;
      chk("reset_data", 64'(reg_rd_data), 64'h0);
      chk("reset_busy", 64'(reg_rd_busy), 64'h0);
      step();
    end
    chk("reset_cnt", 64'(busy_count), 64'h0);
    chk("reset_err", 64'(rsv_err), 64'h0);

    // Directed table: bypass, double reserve, reserve+write, flush, register 0.
    foreach (tbl[i]) begin
      drive(tbl[i].we, tbl[i].wd, tbl[i].wdat, tbl[i].re, tbl[i].ra, tbl[i].fl, tbl[i].a0, tbl[i].a1);
      #1;
      chk($sformatf("tbl%0d_data", i), 64'(reg_rd_data), 64'({tbl[i].d1, tbl[i].d0}));
      chk($sformatf("tbl%0d_busy", i), 64'(reg_rd_busy), 64'({tbl[i].b1, tbl[i].b0}));
      chk($sformatf("tbl%0d_ok", i),   64'(rsv_ok),      64'(tbl[i].ok));
      chk($sformatf("tbl%0d_cnt", i),  64'(busy_count),  64'(tbl[i].cnt));
      chk($sformatf("tbl%0d_err", i),  64'(rsv_err),     64'(tbl[i].err));
      step();
    end

    // Reset asserted between edges must clear outputs immediately.
    drive(0, 0, 16'h0, 1, 7, 0, 7, 3);
    step();
    drive(1, 3, 16'hFFFF, 0, 0, 0, 3, 7);
    #1;
    chk("pre_rst_data", 64'(reg_rd_data), 64'h0000_FFFF);
    chk("pre_rst_busy", 64'(reg_rd_busy), 64'h2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_data", 64'(reg_rd_data), 64'h0);
    chk("async_rst_busy", 64'(reg_rd_busy), 64'h0);
    chk("async_rst_cnt",  64'(busy_count),  64'h0);
    chk("async_rst_err",  64'(rsv_err),     64'h0);
    drive(0, 0, 16'h0, 0, 0, 0, 3, 2);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    check_model("post_rst");
    step();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      logic fl;
      fl = ($urandom_range(0, 15) == 0);
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
            fl ? 1'b0 : 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), fl,
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      #1;
      check_model("rand");
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the register width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 3; the block holds REG_NUM = 2**ADDR_WIDTH registers.
REQ-003 The block SHALL have parameter NUM_RD_PORTS, default 2, legal range 1..4, giving the number of independent read ports.
REQ-004 The block SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads as zero.
REQ-005 The block SHALL have parameter BYPASS_EN, default 1; when 1, a same-cycle write forwards to the read ports.
REQ-006 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-007 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk_in  input  1  clock; all state changes on the rising edge.
- rst_n_in  input  1  asynchronous active-low reset.
- reg_wr_en  input  1  write strobe.
- reg_wr_dest  input  ADDR_WIDTH  write address.
- reg_wr_data  input  DATA_WIDTH  write data.
- rsv_en  input  1  reserve a destination (mark pending).
- rsv_addr  input  ADDR_WIDTH  register to reserve.
- sb_flush  input  1  clear all pending marks.
- reg_rd_addr  input  NUM_RD_PORTS*ADDR_WIDTH  packed read addresses; port k uses slice k.
- reg_rd_data  output  NUM_RD_PORTS*DATA_WIDTH  packed read data.
- reg_rd_busy  output  NUM_RD_PORTS  read register is pending.
- rsv_ok  output  1  the current reservation is accepted.
- busy_count  output  ADDR_WIDTH+1  number of pending registers.
- rsv_err  output  1  sticky flag: a reservation was rejected.

Function
REQ-008 Writes SHALL update reg_array[reg_wr_dest] on the clock edge while reg_wr_en is 1; write latency is one cycle.
REQ-009 Reads SHALL be combinational: reg_rd_data slice k equals reg_array[addr k].
REQ-010 With BYPASS_EN=1, when reg_wr_en is 1 and reg_wr_dest equals addr k, slice k SHALL equal reg_wr_data in the same cycle.
REQ-011 With ZERO_REG=1:
- writes to register 0 are discarded;
- reads of register 0 return 0, and bypass never applies to register 0;
- rsv_en to register 0 is ignored, with rsv_ok=1 and no counter change.
REQ-012 The scoreboard SHALL hold one busy bit per register.
- rsv_en with rsv_ok=1 sets busy[rsv_addr] at the next edge.
- reg_wr_en clears busy[reg_wr_dest] at the next edge.
REQ-013 A reservation and a write to the same address in the same cycle SHALL leave the busy bit set, because the new reservation wins.
REQ-014 rsv_ok SHALL be 1 when the target is not busy, or when it is busy and being written in the same cycle; otherwise rsv_ok SHALL be 0.
REQ-015 A rejected reservation (rsv_en=1, rsv_ok=0) SHALL NOT change any busy bit and SHALL set rsv_err at the next edge.
REQ-016 reg_rd_busy[k] SHALL be busy[addr k] AND NOT (BYPASS_EN AND reg_wr_en AND reg_wr_dest==addr k).
REQ-017 busy_count SHALL always equal the population count of the busy bits.
- It updates by +1, 0 or -1 per cycle and never wraps.
- Its maximum is REG_NUM-ZERO_REG.
REQ-018 sb_flush SHALL clear all busy bits and busy_count at the next edge.
- sb_flush overrides rsv_en and the write-clear in the same cycle.
- sb_flush does not alter register contents or rsv_err.
REQ-019 A write to a register that is not busy SHALL be legal; it updates data and leaves busy_count unchanged.

Reset
REQ-020 While rst_n_in is 0, regardless of clock, the block SHALL:
- clear all registers, all busy bits, busy_count and rsv_err to 0;
- drive reg_rd_data to 0 and reg_rd_busy to 0.
REQ-021 rsv_err SHALL clear only on reset.
REQ-022 Reset asserted mid-operation SHALL abandon pending reservations; the first edge after release behaves as from an empty scoreboard.

Structure
REQ-023 Package register_file_pkg SHALL hold the default DATA_WIDTH/ADDR_WIDTH constants and a function giving the address slice of a packed read-port vector.
REQ-024 Busy bits, rsv_ok, rsv_err and busy_count SHALL live in the sub-module regfile_scoreboard; the data array and bypass muxes SHALL stay in register_file_mp.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Reset then read all 8 registers on both ports -> all data 0, busy 0, busy_count 0.
- Write r3=0xBEEF while port0 reads r3 -> port0 shows 0xBEEF the same cycle (BYPASS_EN=1); the next cycle it is still 0xBEEF from the array.
- Reserve r5, then the next cycle reserve r5 again -> second rsv_ok=0, rsv_err=1 next cycle, busy_count stays 1.
- Reserve r2 and write r2 in the same cycle, with r2 busy -> rsv_ok=1, r2 stays busy, busy_count unchanged.
- Reserve r1,r2,r4, then assert sb_flush together with rsv_en r6 -> all busy 0, busy_count 0.
- Write r0=0x1234 and reserve r0 -> reads of r0 return 0, busy_count 0; then assert rst_n_in low mid-sequence -> outputs 0 immediately, without waiting for a clock edge.
